mux_select_scanner: RTL and testbench

- Sequential control stage placed directly upstream and downstream of the 1-bit 4-to-1 mux.
- Drives the mux select lines s1/s0 and steps through the enabled channels in ascending order.
- Holds each select for a programmable settle time, then samples the mux output.
- Assembles the four samples into a 4-bit word and reports it with a one-cycle valid pulse, under a start/busy handshake.

---
 rtl/mux_select_scanner.sv | 149 ++++++++++++++
 tb/tb_mux_select_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_scanner.sv
// Sequencer around a 1-bit 4:1 mux: walks the enabled channels in ascending order,
// holds each select for DWELL cycles, samples the mux output on the last dwell cycle,
// then reports the assembled 4-bit word with a one-cycle valid pulse.
module mux_select_scanner #(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] ch_mask,
  input  logic       mux_in,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       valid,
  output logic [3:0] data_out
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned CH_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [CH_W-1:0]   ch_q,     ch_d;
  logic [NCH-1:0]    mask_q,   mask_d;
  logic [NCH-1:0]    shadow_q, shadow_d;
  logic [NCH-1:0]    data_q,   data_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              busy_q,   busy_d;
  logic              valid_q,  valid_d;

  logic [CH_W-1:0]   first_ch_c;
  logic [CH_W-1:0]   next_ch_c;
  logic              has_next_c;

  // Lowest enabled channel of the incoming mask (first channel of a new scan).
  always_comb begin
    first_ch_c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch_c = CH_W'(i);
    end
  end

  // Lowest enabled channel strictly above the current one in the latched mask.
  always_comb begin
    next_ch_c  = ch_q;
    has_next_c = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch_c  = CH_W'(i);
        has_next_c = 1'b1;
      end
    end
  end

  // State and datapath registers; asynchronous reset aborts any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic; ch_q is forced to 0 outside SCAN so it can drive the selects directly.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d   = ch_mask;
          shadow_d = '0;
          cnt_d    = '0;
          if (ch_mask != '0) begin
            ch_d    = first_ch_c;
            busy_d  = 1'b1;
            state_d = ST_SCAN;
          end else begin
            data_d  = '0;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_SCAN: begin
        if (cnt_q == CNT_LAST) begin
          shadow_d[ch_q] = mux_in;
          cnt_d          = '0;
          if (has_next_c) begin
            ch_d = next_ch_c;
          end else begin
            ch_d    = '0;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            data_d  = shadow_d;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s1       = ch_q[1];
  assign s0       = ch_q[0];
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_mux_select_scanner.sv
// Bench for mux_select_scanner: two instances (DWELL=2 and DWELL=3) share stimulus and a
// behavioural mux; a scan-level model predicts every output and is compared each cycle.
module tb_mux_select_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] ch_mask;
  logic [3:0] iv;

  logic       s1_a, s0_a, busy_a, valid_a;
  logic [3:0] data_a;
  logic       s1_b, s0_b, busy_b, valid_b;
  logic [3:0] data_b;
  logic       mux_a, mux_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_a = iv[{s1_a, s0_a}];
  assign mux_b = iv[{s1_b, s0_b}];

  mux_select_scanner #(.DWELL(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .mux_in(mux_a),
    .s1(s1_a), .s0(s0_a), .busy(busy_a), .valid(valid_a), .data_out(data_a)
  );

  mux_select_scanner #(.DWELL(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .mux_in(mux_b),
    .s1(s1_b), .s0(s0_b), .busy(busy_b), .valid(valid_b), .data_out(data_b)
  );

  // Scan-level reference: t counts edges since acceptance, channel list built from the mask.
  typedef struct packed {
    logic            active;
    logic            in_done;
    int              t;
    int              k;
    logic [3:0][1:0] chans;
    logic [3:0]      shadow;
    logic [1:0]      sel;
    logic            busy;
    logic            valid;
    logic [3:0]      data;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t step(mdl_t m, logic st, logic [3:0] msk, logic [3:0] inp, int dw);
    mdl_t n = m;
    int   idx;
    n.valid = 1'b0;
    if (m.active) begin
      n.t = m.t + 1;
      if (n.t % dw == 0) begin
        idx = n.t / dw - 1;
        n.shadow[m.chans[idx]] = inp[m.chans[idx]];
      end
      if (n.t == m.k * dw) begin
        n.active  = 1'b0;
        n.in_done = 1'b1;
        n.busy    = 1'b0;
        n.sel     = 2'b00;
        n.valid   = 1'b1;
        n.data    = n.shadow;
      end else begin
        n.sel = m.chans[n.t / dw];
      end
    end else if (m.in_done) begin
      n.in_done = 1'b0;
    end else if (st) begin
      n.k      = 0;
      n.t      = 0;
      n.shadow = '0;
      for (int c = 0; c < 4; c++) begin
        if (msk[c]) begin
          n.chans[n.k] = 2'(c);
          n.k          = n.k + 1;
        end
      end
      if (n.k == 0) begin
        n.in_done = 1'b1;
        n.valid   = 1'b1;
        n.data    = '0;
      end else begin
        n.active = 1'b1;
        n.busy   = 1'b1;
        n.sel    = n.chans[0];
      end
    end
    return n;
  endfunction

  // Advance the model on each active edge; reset clears it like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = step(ma, start, ch_mask, iv, 2);
      mb = step(mb, start, ch_mask, iv, 3);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    chk("a_sel",   8'({s1_a, s0_a}), 8'(ma.sel));
    chk("a_busy",  8'(busy_a),       8'(ma.busy));
    chk("a_valid", 8'(valid_a),      8'(ma.valid));
    chk("a_data",  8'(data_a),       8'(ma.data));
    chk("b_sel",   8'({s1_b, s0_b}), 8'(mb.sel));
    chk("b_busy",  8'(busy_b),       8'(mb.busy));
    chk("b_valid", 8'(valid_b),      8'(mb.valid));
    chk("b_data",  8'(data_b),       8'(mb.data));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present start for one edge (E0) and return 1 time unit after it.
  task automatic go(input logic [3:0] m);
    ch_mask = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  logic [1:0] exp_full [8];
  logic [1:0] exp_sparse [4];
  int nv_a, nv_b;

  initial begin
    exp_full   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    exp_sparse = '{2'd0, 2'd0, 2'd2, 2'd2};
    rst_n   = 1'b0;
    start   = 1'b0;
    ch_mask = 4'b0000;
    iv      = 4'b0000;
    #2;
    chk("rst_sel",   8'({s1_a, s0_a, s1_b, s0_b}), 8'h00);
    chk("rst_flags", 8'({busy_a, valid_a, busy_b, valid_b}), 8'h00);
    chk("rst_data",  8'({data_a, data_b}), 8'h00);
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(2);

    // Full scan, i0=1 i1=0 i2=1 i3=1
    iv = 4'b1101;
    go(4'b1111);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("full_sel",  8'({s1_a, s0_a}), 8'(exp_full[j]));
      chk("full_busy", 8'(busy_a), 8'd1);
      chk("full_noval", 8'(valid_a), 8'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("full_valid", 8'(valid_a), 8'd1);
    chk("full_data",  8'(data_a), 8'h0d);
    chk("full_busy_end", 8'(busy_a), 8'd0);
    cyc(1);
    @(negedge clk);
    chk("full_valid_drop", 8'(valid_a), 8'd0);
    cyc(8);

    // Sparse mask 0101
    go(4'b0101);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("sparse_sel", 8'({s1_a, s0_a}), 8'(exp_sparse[j]));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("sparse_valid", 8'(valid_a), 8'd1);
    chk("sparse_data",  8'(data_a), 8'h05);
    cyc(10);

    // Empty mask
    go(4'b0000);
    @(negedge clk);
    chk("empty_busy",  8'({busy_a, busy_b}), 8'd0);
    chk("empty_valid", 8'({valid_a, valid_b}), 8'h03);
    chk("empty_data",  8'({data_a, data_b}), 8'h00);
    cyc(1);
    @(negedge clk);
    chk("empty_after", 8'({busy_a, valid_a, busy_b, valid_b}), 8'h00);
    cyc(3);

    // Dwell sampling on the DWELL=3 instance: i0 rises just before the last dwell cycle
    iv = 4'b0000;
    go(4'b0001);
    cyc(2);
    iv = 4'b0001;
    cyc(1);
    @(negedge clk);
    chk("dwell_valid_b", 8'(valid_b), 8'd1);
    chk("dwell_data_b",  8'(data_b), 8'h01);
    chk("dwell_data_a",  8'(data_a), 8'h00);
    cyc(4);

    // Handshake: mask change after acceptance and a re-pulsed start are both ignored
    iv = 4'b1101;
    go(4'b1111);
    ch_mask = 4'b0001;
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    nv_a = 0;
    nv_b = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (valid_a) nv_a++;
      if (valid_b) nv_b++;
      @(posedge clk);
      #1;
    end
    chk("hs_pulses_a", 8'(nv_a), 8'd1);
    chk("hs_pulses_b", 8'(nv_b), 8'd1);
    chk("hs_data",     8'({data_a, data_b}), 8'hdd);
    chk("hs_idle",     8'({busy_a, busy_b}), 8'd0);

    // Asynchronous reset mid-scan
    go(4'b1111);
    cyc(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel",   8'({s1_a, s0_a, s1_b, s0_b}), 8'h00);
    chk("arst_flags", 8'({busy_a, valid_a, busy_b, valid_b}), 8'h00);
    chk("arst_data",  8'({data_a, data_b}), 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    nv_a = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (valid_a || valid_b || busy_a || busy_b) nv_a++;
      @(posedge clk);
      #1;
    end
    chk("arst_quiet", 8'(nv_a), 8'd0);

    // Randomized traffic with occasional asynchronous resets
    for (int j = 0; j < 1500; j++) begin
      iv      = 4'($urandom);
      ch_mask = 4'($urandom);
      start   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
